ctrl_stream_dispatcher: RTL and testbench

//  Parametrised multi-channel dispatcher for the per-channel control stream feeding the fano_decoder channels.

---
 rtl/ctrl_stream_dispatcher_if.sv | 29 ++
 rtl/ctrl_stream_dispatcher.sv | 127 ++++++++++++
 tb/tb_ctrl_stream_dispatcher.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_stream_dispatcher_if.sv
// Control-stream bus between the upstream ctrl source and the per-channel dispatcher.
// The master drives the input word and the consumer readies; the slave returns the per-channel stream and flags.
interface ctrl_stream_dispatcher_if #(
   parameter int DATA_WIDTH = 24,
   parameter int N_CHS      = 4,
   parameter int SEL_W      = (N_CHS > 1) ? $clog2(N_CHS) : 1
);
   logic [SEL_W-1:0]            i_sel;
   logic                        i_bcast;
   logic                        i_valid;
   logic [DATA_WIDTH-1:0]       i_data;
   logic                        o_ready;
   logic [N_CHS-1:0]            o_valid;
   logic [DATA_WIDTH*N_CHS-1:0] o_data;
   logic [N_CHS-1:0]            i_ready;
   logic [N_CHS-1:0]            o_ovf;
   logic                        o_sel_err;
   logic                        i_clr;

   modport master (
      output i_sel, i_bcast, i_valid, i_data, i_ready, i_clr,
      input  o_ready, o_valid, o_data, o_ovf, o_sel_err
   );

   modport slave (
      input  i_sel, i_bcast, i_valid, i_data, i_ready, i_clr,
      output o_ready, o_valid, o_data, o_ovf, o_sel_err
   );
endinterface

// File: rtl/ctrl_stream_dispatcher.sv
// Routes one control word per cycle into per-channel FIFOs (single target or broadcast).
// Each channel presents its head word through a registered first-word-fall-through stage.
module ctrl_stream_dispatcher #(
   parameter int DATA_WIDTH   = 24,
   parameter int N_CHS        = 4,
   parameter int FIFO_DEPTH   = 8,
   parameter int DROP_ON_FULL = 0
) (
   input logic                     clk,
   input logic                     reset_n,
   ctrl_stream_dispatcher_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic [N_CHS-1:0]      tgt;
   logic [N_CHS-1:0]      full;
   logic [N_CHS-1:0]      wrEn;
   logic [N_CHS-1:0]      rdEn;
   logic [N_CHS-1:0]      ovfSet;
   logic                  selErr;
   logic                  ready;
   logic                  accept;

   logic [PW-1:0]         wrPtr_q [N_CHS];
   logic [PW-1:0]         wrPtr_d [N_CHS];
   logic [PW-1:0]         rdPtr_q [N_CHS];
   logic [PW-1:0]         rdPtr_d [N_CHS];
   logic [CW-1:0]         count_q [N_CHS];
   logic [CW-1:0]         count_d [N_CHS];
   logic [N_CHS-1:0]      valid_q;
   logic [N_CHS-1:0]      valid_d;
   logic [DATA_WIDTH-1:0] data_q  [N_CHS];
   logic [DATA_WIDTH-1:0] data_d  [N_CHS];
   logic [DATA_WIDTH-1:0] mem_q   [N_CHS][FIFO_DEPTH];
   logic [N_CHS-1:0]      ovf_q;
   logic [N_CHS-1:0]      ovf_d;
   logic                  selErr_q;
   logic                  selErr_d;

   // An out-of-range select yields an empty target set: the word is swallowed and flagged.
   always_comb begin
      tgt    = '0;
      selErr = !bus.i_bcast && (32'(bus.i_sel) >= 32'(N_CHS));
      for (int k = 0; k < N_CHS; k++) begin
         tgt[k]  = bus.i_bcast || (32'(bus.i_sel) == 32'(k));
         full[k] = (count_q[k] == FULL_CNT);
      end
   end

   assign ready  = (DROP_ON_FULL != 0) ? 1'b1 : ~|(tgt & full);
   assign accept = bus.i_valid && ready;
   assign wrEn   = {N_CHS{accept}} & tgt & ~full;
   assign ovfSet = (DROP_ON_FULL != 0) ? ({N_CHS{accept}} & tgt & full) : '0;
   assign rdEn   = valid_q & bus.i_ready;

   // The output stage always mirrors the head slot; the incoming word bypasses memory
   // when it lands exactly on the new head position.
   always_comb begin
      for (int k = 0; k < N_CHS; k++) begin
         wrPtr_d[k] = wrPtr_q[k] + PW'(wrEn[k]);
         rdPtr_d[k] = rdPtr_q[k] + PW'(rdEn[k]);
         count_d[k] = count_q[k];
         if (wrEn[k] && !rdEn[k]) begin
            count_d[k] = count_q[k] + CW'(1);
         end else if (!wrEn[k] && rdEn[k]) begin
            count_d[k] = count_q[k] - CW'(1);
         end
         valid_d[k] = (count_d[k] != '0);
         data_d[k]  = data_q[k];
         if (count_d[k] != '0) begin
            data_d[k] = (wrEn[k] && (wrPtr_q[k] == rdPtr_d[k])) ? bus.i_data
                                                                : mem_q[k][rdPtr_d[k]];
         end
      end
   end

   always_comb begin
      ovf_d    = (bus.i_clr ? '0 : ovf_q) | ovfSet;
      selErr_d = (bus.i_clr ? 1'b0 : selErr_q) | (accept && selErr);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < N_CHS; k++) begin
            wrPtr_q[k] <= '0;
            rdPtr_q[k] <= '0;
            count_q[k] <= '0;
            data_q[k]  <= '0;
         end
         valid_q  <= '0;
         ovf_q    <= '0;
         selErr_q <= 1'b0;
      end else begin
         for (int k = 0; k < N_CHS; k++) begin
            wrPtr_q[k] <= wrPtr_d[k];
            rdPtr_q[k] <= rdPtr_d[k];
            count_q[k] <= count_d[k];
            data_q[k]  <= data_d[k];
         end
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         selErr_q <= selErr_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < N_CHS; k++) begin
         if (wrEn[k]) begin
            mem_q[k][wrPtr_q[k]] <= bus.i_data;
         end
      end
   end

   always_comb begin
      bus.o_data = '0;
      for (int k = 0; k < N_CHS; k++) begin
         bus.o_data[DATA_WIDTH*k +: DATA_WIDTH] = data_q[k];
      end
   end

   assign bus.o_ready   = ready;
   assign bus.o_valid   = valid_q;
   assign bus.o_ovf     = ovf_q;
   assign bus.o_sel_err = selErr_q;
endmodule

// File: tb/tb_ctrl_stream_dispatcher.sv
// Directed bench for the control-stream dispatcher: a 4-channel backpressure instance,
// a 4-channel drop-on-full instance and a 3-channel instance for out-of-range selects.
module tb_ctrl_stream_dispatcher;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   rcv;
   int   expWord;
   logic accepting;

   always #5 clk = ~clk;

   ctrl_stream_dispatcher_if #(.DATA_WIDTH(24), .N_CHS(4)) busA ();
   ctrl_stream_dispatcher_if #(.DATA_WIDTH(24), .N_CHS(4)) busB ();
   ctrl_stream_dispatcher_if #(.DATA_WIDTH(24), .N_CHS(3)) busC ();

   ctrl_stream_dispatcher #(.DATA_WIDTH(24), .N_CHS(4), .FIFO_DEPTH(8), .DROP_ON_FULL(0))
      dutA (.clk(clk), .reset_n(reset_n), .bus(busA.slave));
   ctrl_stream_dispatcher #(.DATA_WIDTH(24), .N_CHS(4), .FIFO_DEPTH(8), .DROP_ON_FULL(1))
      dutB (.clk(clk), .reset_n(reset_n), .bus(busB.slave));
   ctrl_stream_dispatcher #(.DATA_WIDTH(24), .N_CHS(3), .FIFO_DEPTH(8), .DROP_ON_FULL(0))
      dutC (.clk(clk), .reset_n(reset_n), .bus(busC.slave));

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Presents one word to the backpressure instance and advances past the next edge.
   task automatic applyStimulus(input logic [1:0] sel, input logic bcast, input logic [23:0] data);
      busA.i_sel   = sel;
      busA.i_bcast = bcast;
      busA.i_data  = data;
      busA.i_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      busA.i_sel = '0; busA.i_bcast = 1'b0; busA.i_valid = 1'b0; busA.i_data = '0;
      busA.i_ready = 4'b1111; busA.i_clr = 1'b0;
      busB.i_sel = '0; busB.i_bcast = 1'b0; busB.i_valid = 1'b0; busB.i_data = '0;
      busB.i_ready = 4'b1111; busB.i_clr = 1'b0;
      busC.i_sel = '0; busC.i_bcast = 1'b0; busC.i_valid = 1'b0; busC.i_data = '0;
      busC.i_ready = 3'b111; busC.i_clr = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_valid", 32'(busA.o_valid), 32'(0));
      checkOutput("rst_data", 32'(busA.o_data[31:0]), 32'(0));
      checkOutput("rst_ovf", 32'(busB.o_ovf), 32'(0));
      checkOutput("rst_selerr", 32'(busC.o_sel_err), 32'(0));
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_ready", 32'(busA.o_ready), 32'(1));

      // Test 1: three words to channel 2, all consumers ready
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(2'd2, 1'b0, 24'(i));
         checkOutput("t1_valid", 32'(busA.o_valid), 32'(4'b0100));
         checkOutput("t1_data", 32'(busA.o_data[71:48]), 32'(i));
      end
      busA.i_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("t1_idle", 32'(busA.o_valid), 32'(0));
      checkOutput("t1_hold_last", 32'(busA.o_data[71:48]), 32'(3));

      // Test 2: nine words to stalled channel 1
      busA.i_ready = 4'b1101;
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(2'd1, 1'b0, 24'(i));
      end
      busA.i_data = 24'd9;
      #1;
      checkOutput("t2_ready_full", 32'(busA.o_ready), 32'(0));
      checkOutput("t2_valid", 32'(busA.o_valid), 32'(4'b0010));
      checkOutput("t2_head", 32'(busA.o_data[47:24]), 32'(1));
      @(posedge clk);
      #1;
      checkOutput("t2_hold", 32'(busA.o_data[47:24]), 32'(1));
      busA.i_ready = 4'b1111;
      #1;
      checkOutput("t2_ready_same_cycle", 32'(busA.o_ready), 32'(0));
      rcv = 0;
      expWord = 1;
      for (int cyc = 0; cyc < 30 && rcv < 9; cyc++) begin
         accepting = busA.i_valid && busA.o_ready;
         if (busA.o_valid[1]) begin
            checkOutput("t2_order", 32'(busA.o_data[47:24]), 32'(expWord));
            expWord++;
            rcv++;
         end
         @(posedge clk);
         #1;
         if (accepting) busA.i_valid = 1'b0;
      end
      checkOutput("t2_count", 32'(rcv), 32'(9));
      @(posedge clk);
      #1;
      checkOutput("t2_drained", 32'(busA.o_valid), 32'(0));

      // Test 3: broadcast waits for stalled, full channel 3
      busA.i_ready = 4'b0111;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(2'd3, 1'b0, 24'h30 + 24'(i));
      end
      busA.i_bcast = 1'b1;
      busA.i_data  = 24'hABCDEF;
      #1;
      checkOutput("t3_ready_blocked", 32'(busA.o_ready), 32'(0));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput("t3_no_write", 32'(busA.o_valid), 32'(4'b1000));
      end
      busA.i_ready = 4'b1111;
      @(posedge clk);
      #1;
      checkOutput("t3_ready_freed", 32'(busA.o_ready), 32'(1));
      checkOutput("t3_still_none", 32'(busA.o_valid), 32'(4'b1000));
      @(posedge clk);
      #1;
      busA.i_valid = 1'b0;
      busA.i_bcast = 1'b0;
      checkOutput("t3_all_valid", 32'(busA.o_valid), 32'(4'b1111));
      checkOutput("t3_ch0", 32'(busA.o_data[23:0]), 32'h00ABCDEF);
      checkOutput("t3_ch1", 32'(busA.o_data[47:24]), 32'h00ABCDEF);
      checkOutput("t3_ch2", 32'(busA.o_data[71:48]), 32'h00ABCDEF);
      checkOutput("t3_ch3_head", 32'(busA.o_data[95:72]), 32'h32);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("t3_ch3_bcast", 32'(busA.o_data[95:72]), 32'h00ABCDEF);
      checkOutput("t3_ch3_only", 32'(busA.o_valid), 32'(4'b1000));
      @(posedge clk);
      #1;
      checkOutput("t3_drained", 32'(busA.o_valid), 32'(0));

      // Test 4: drop-on-full with sticky overflow on channel 0
      busB.i_ready = 4'b1110;
      busB.i_sel   = 2'd0;
      for (int i = 1; i <= 10; i++) begin
         busB.i_valid = 1'b1;
         busB.i_data  = 24'(i);
         #1;
         if (i > 8) checkOutput("t4_ready_const", 32'(busB.o_ready), 32'(1));
         @(posedge clk);
         #1;
      end
      busB.i_valid = 1'b0;
      checkOutput("t4_ovf", 32'(busB.o_ovf), 32'(4'b0001));
      checkOutput("t4_valid", 32'(busB.o_valid), 32'(4'b0001));
      busB.i_ready = 4'b1111;
      for (int i = 1; i <= 8; i++) begin
         checkOutput("t4_word", 32'(busB.o_data[23:0]), 32'(i));
         @(posedge clk);
         #1;
      end
      checkOutput("t4_empty", 32'(busB.o_valid), 32'(0));
      checkOutput("t4_ovf_sticky", 32'(busB.o_ovf), 32'(4'b0001));
      busB.i_clr = 1'b1;
      @(posedge clk);
      #1;
      busB.i_clr = 1'b0;
      checkOutput("t4_ovf_clr", 32'(busB.o_ovf), 32'(0));

      // Test 5: out-of-range select on the 3-channel instance, then reset mid-stream
      busC.i_sel   = 2'd3;
      busC.i_bcast = 1'b0;
      busC.i_data  = 24'h55;
      busC.i_valid = 1'b1;
      #1;
      checkOutput("t5_ready_badsel", 32'(busC.o_ready), 32'(1));
      @(posedge clk);
      #1;
      busC.i_valid = 1'b0;
      checkOutput("t5_selerr", 32'(busC.o_sel_err), 32'(1));
      checkOutput("t5_no_valid", 32'(busC.o_valid), 32'(0));
      @(posedge clk);
      #1;
      checkOutput("t5_no_valid_later", 32'(busC.o_valid), 32'(0));
      busC.i_ready = 3'b110;
      busC.i_sel   = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         busC.i_valid = 1'b1;
         busC.i_data  = 24'(i);
         @(posedge clk);
         #1;
      end
      busC.i_valid = 1'b0;
      checkOutput("t5_half_full", 32'(busC.o_valid), 32'(3'b001));
      checkOutput("t5_head", 32'(busC.o_data[23:0]), 32'(1));
      reset_n = 1'b0;
      #1;
      checkOutput("t5_rst_valid", 32'(busC.o_valid), 32'(0));
      checkOutput("t5_rst_selerr", 32'(busC.o_sel_err), 32'(0));
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      busC.i_ready = 3'b111;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t5_empty_after", 32'(busC.o_valid), 32'(0));
      checkOutput("t5_ready_after", 32'(busC.o_ready), 32'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
